// File: rtl/sim_trig_pkg.sv
// Shared definitions for the frame trigger stage:
// FSM state encoding and the default counter width.
package sim_trig_pkg;

  localparam int CW_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_COUNT = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/jtframe_sync_edge.sv
// Multi-flop synchronizer with a history flop that
// produces a one-cycle strobe on the selected edge.
module jtframe_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit FALL        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_q;

  assign w_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_hist <= w_q;
    end
  end

  assign o_edge = FALL ? (r_hist & ~w_q)
                       : (~r_hist & w_q);

endmodule

// File: rtl/sim_frame_trigger.sv
// Frame counter and dump-window generator that drives
// the simulation dump controller.
import sim_trig_pkg::*;

module sim_frame_trigger #(
  parameter int SYNC_STAGES = 2,
  parameter bit VS_ACT_LOW  = 1'b1,
  parameter bit WAIT_DL     = 1'b0,
  parameter int GUARD       = 20000,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          downloading,
  input  logic [CW-1:0] dump_start,
  input  logic [CW-1:0] dump_len,
  input  logic [CW-1:0] max_frames,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_on,
  output logic          dump_open,
  output logic          dump_close,
  output logic          sim_finish,
  output logic [2:0]    state
);

  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [GW-1:0] GMAX = GW'(GUARD);

  logic          w_frame_edge;
  logic          w_dl_fall;
  logic          w_guard_ok;
  logic          w_fin_hit;
  logic          w_close_hit;
  logic          w_start0;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_dumped_nxt;

  logic [GW-1:0] r_guard;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_dumped;
  logic          r_on;
  logic          r_open;
  logic          r_close;
  logic          r_fin;
  state_t        r_state;

  jtframe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .FALL       (VS_ACT_LOW)
  ) u_vs (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (vs),
    .o_edge(w_frame_edge)
  );

  jtframe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .FALL       (1'b1)
  ) u_dl (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (downloading),
    .o_edge(w_dl_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_guard <= '0;
    end else if (r_guard != GMAX) begin
      r_guard <= r_guard + GW'(1);
    end
  end

  assign w_guard_ok = (r_guard == GMAX);

  // Counter sticks at all-ones rather than wrapping
  assign w_cnt_nxt = (&r_cnt) ? r_cnt
                              : r_cnt + CW'(1);
  assign w_dumped_nxt = r_dumped + CW'(1);
  assign w_start0 = (dump_start == '0);

  assign w_fin_hit = w_frame_edge
                   && (max_frames != '0)
                   && (w_cnt_nxt == max_frames);
  assign w_close_hit = (dump_len != '0)
                     && (w_dumped_nxt == dump_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dumped <= '0;
      r_on     <= 1'b0;
      r_open   <= 1'b0;
      r_close  <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_open  <= 1'b0;
      r_close <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (WAIT_DL) begin
            r_state <= S_WAIT;
          end else if (w_start0) begin
            r_state  <= S_DUMP;
            r_dumped <= '0;
            r_on     <= 1'b1;
            r_open   <= 1'b1;
          end else begin
            r_state <= S_COUNT;
          end
        end
        S_WAIT: begin
          if (w_dl_fall && w_guard_ok) begin
            if (w_start0) begin
              r_state  <= S_DUMP;
              r_dumped <= '0;
              r_on     <= 1'b1;
              r_open   <= 1'b1;
            end else begin
              r_state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (w_frame_edge) begin
            r_cnt <= w_cnt_nxt;
            if (w_fin_hit) begin
              r_fin   <= 1'b1;
              r_state <= S_DONE;
            end else if (r_cnt == dump_start) begin
              r_state  <= S_DUMP;
              r_dumped <= '0;
              r_on     <= 1'b1;
              r_open   <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (w_frame_edge) begin
            r_cnt <= w_cnt_nxt;
            if (w_fin_hit) begin
              r_fin <= 1'b1;
            end
            // A finish and a length close share one pulse
            if (w_fin_hit || w_close_hit) begin
              r_state <= S_DONE;
              r_on    <= 1'b0;
              r_close <= 1'b1;
            end else begin
              r_dumped <= w_dumped_nxt;
            end
          end
        end
        S_DONE: begin
          if (w_frame_edge) begin
            r_cnt <= w_cnt_nxt;
            if (w_fin_hit) begin
              r_fin <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign frame_cnt  = r_cnt;
  assign dump_on    = r_on;
  assign dump_open  = r_open;
  assign dump_close = r_close;
  assign sim_finish = r_fin;
  assign state      = r_state;

endmodule
